clk_analyzer: RTL and testbench

Measurement counterpart to `clk_generator`. Watches the derived pair `clk0`/`clk1` and recovers the programmed clk1 duty cycle and phase offset. Reports them on parallel result outputs. Also re-emits them on the same two-beat `go`/`datain` programming protocol the generator consumes, so the result can be compared against, or replayed into, a generator. Lives in the clock-generation test/loopback path, in the same `clk` domain as the generator.

---
 rtl/clk_analyzer.sv | 195 +++++++++++++++++++
 tb/tb_clk_analyzer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_analyzer.sv
// Recovers clk1 duty cycle and phase offset relative to clk0 and reports them
// on parallel outputs and as a two-beat go/data frame matching clk_generator.
module clk_analyzer #(
    parameter int unsigned W      = 3,
    parameter int unsigned PERIOD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clk0,
    input  logic         clk1,
    output logic         busy,
    output logic         valid,
    output logic         err,
    output logic [W-1:0] duty_o,
    output logic [W-1:0] phase_o,
    output logic         go_out,
    output logic [W-1:0] dataout
);

    localparam int unsigned CW = W + 1;
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_LAST     = CW'(PERIOD - 1);
    localparam logic [CW-1:0] C_ARM_LAST = CW'(2 * PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PHASE, S_DUTY, S_EMIT1, S_EMIT2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_p0;
    logic            r_p1;
    logic            r_any1;
    logic [W-1:0]    r_duty;
    logic [W-1:0]    r_phase;
    logic            r_busy;
    logic            r_valid;
    logic            r_err;
    logic [W-1:0]    r_duty_o;
    logic [W-1:0]    r_phase_o;
    logic            r_go;
    logic [W-1:0]    r_dataout;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_any1_nxt;
    logic [W-1:0]    w_duty_nxt;
    logic [W-1:0]    w_phase_nxt;
    logic            w_err_nxt;
    logic            w_busy_nxt;
    logic            w_valid_nxt;
    logic            w_go_nxt;
    logic [W-1:0]    w_dataout_nxt;
    logic [W-1:0]    w_duty_o_nxt;
    logic [W-1:0]    w_phase_o_nxt;
    logic            w_rise0;
    logic            w_rise1;

    assign w_rise0 = clk0 & ~r_p0;
    assign w_rise1 = clk1 & ~r_p1;

    // State, measurement datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_p0      <= 1'b0;
            r_p1      <= 1'b0;
            r_any1    <= 1'b0;
            r_duty    <= '0;
            r_phase   <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_duty_o  <= '0;
            r_phase_o <= '0;
            r_go      <= 1'b0;
            r_dataout <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_p0      <= clk0;
            r_p1      <= clk1;
            r_any1    <= w_any1_nxt;
            r_duty    <= w_duty_nxt;
            r_phase   <= w_phase_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_duty_o  <= w_duty_o_nxt;
            r_phase_o <= w_phase_o_nxt;
            r_go      <= w_go_nxt;
            r_dataout <= w_dataout_nxt;
        end
    end

    // Next state and measurement updates
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_any1_nxt  = r_any1;
        w_duty_nxt  = r_duty;
        w_phase_nxt = r_phase;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = '0;
                end
            end
            S_ARM: begin
                if (w_rise0) begin
                    w_cnt_nxt  = C_ONE;
                    w_any1_nxt = clk1;
                    if (w_rise1) begin
                        w_phase_nxt = '0;
                        w_state_nxt = S_DUTY;
                    end else begin
                        w_state_nxt = S_PHASE;
                    end
                end else if (r_cnt == C_ARM_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_PHASE: begin
                if (w_rise1) begin
                    w_phase_nxt = r_cnt[W-1:0];
                    w_cnt_nxt   = C_ONE;
                    w_state_nxt = S_DUTY;
                end else if (r_cnt == C_LAST) begin
                    // No clk1 rise in a full period: flat low is a valid 0/0 result
                    if (r_any1 | clk1) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_duty_nxt  = '0;
                        w_phase_nxt = '0;
                        w_state_nxt = S_EMIT1;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt + C_ONE;
                    w_any1_nxt = r_any1 | clk1;
                end
            end
            S_DUTY: begin
                if (!clk1) begin
                    w_duty_nxt  = r_cnt[W-1:0];
                    w_state_nxt = S_EMIT1;
                end else if (r_cnt == C_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_EMIT1: w_state_nxt = S_EMIT2;
            S_EMIT2: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the upcoming state
    always_comb begin
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_valid_nxt   = 1'b0;
        w_go_nxt      = 1'b0;
        w_dataout_nxt = '0;
        w_duty_o_nxt  = r_duty_o;
        w_phase_o_nxt = r_phase_o;
        if (w_state_nxt == S_EMIT1) begin
            w_valid_nxt   = 1'b1;
            w_go_nxt      = 1'b1;
            w_dataout_nxt = w_duty_nxt;
            w_duty_o_nxt  = w_duty_nxt;
            w_phase_o_nxt = w_phase_nxt;
        end else if (w_state_nxt == S_EMIT2) begin
            w_go_nxt      = 1'b1;
            w_dataout_nxt = r_phase;
        end
    end

    assign busy    = r_busy;
    assign valid   = r_valid;
    assign err     = r_err;
    assign duty_o  = r_duty_o;
    assign phase_o = r_phase_o;
    assign go_out  = r_go;
    assign dataout = r_dataout;

endmodule

// File: tb/tb_clk_analyzer.sv
// Drives programmable clk0/clk1 waveforms into clk_analyzer and compares the
// recovered duty/phase against the programmed generator settings.
module tb_clk_analyzer;

    localparam int W      = 3;
    localparam int PERIOD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         clk0;
    logic         clk1;
    logic         busy;
    logic         valid;
    logic         err;
    logic [W-1:0] duty_o;
    logic [W-1:0] phase_o;
    logic         go_out;
    logic [W-1:0] dataout;

    int n_checks = 0;
    int n_errors = 0;

    int gen_duty  = 1;
    int gen_phase = 0;
    bit hold0     = 1'b0;
    int ph        = 0;
    int exp_duty  = 0;
    int exp_phase = 0;

    clk_analyzer #(.W(W), .PERIOD(PERIOD)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clk0    (clk0),
        .clk1    (clk1),
        .busy    (busy),
        .valid   (valid),
        .err     (err),
        .duty_o  (duty_o),
        .phase_o (phase_o),
        .go_out  (go_out),
        .dataout (dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Ideal generator: clk1 high for gen_duty cycles starting gen_phase after clk0 rise
    function automatic logic gen_clk1(input int phv);
        if (gen_duty >= PERIOD) return 1'b1;
        return (((phv - gen_phase + PERIOD) % PERIOD) < gen_duty);
    endfunction

    initial begin
        clk0 = 1'b0;
        clk1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph   = (ph + 1) % PERIOD;
            clk0 = hold0 ? 1'b0 : (ph < PERIOD / 2);
            clk1 = gen_clk1(ph);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure(input int d, input int p);
        int k;
        int ed;
        int ep;
        gen_duty  = d;
        gen_phase = p;
        repeat (10) @(negedge clk);
        check("idle_busy", busy, 0);
        pulse_start();
        check("busy_rise", busy, 1);
        k = 0;
        while (!(valid || err) && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (!(valid || err)) begin
            check("result_timeout", 0, 1);
        end else if (d >= PERIOD) begin
            check("hold1_err", err, 1);
            check("hold1_valid", valid, 0);
            check("hold1_duty_kept", duty_o, exp_duty);
            check("hold1_phase_kept", phase_o, exp_phase);
            check("hold1_busy", busy, 0);
            @(negedge clk);
            check("err_one_cycle", err, 0);
        end else begin
            ed = d;
            ep = (d == 0) ? 0 : p;
            exp_duty  = ed;
            exp_phase = ep;
            check("valid", valid, 1);
            check("no_err", err, 0);
            check("duty_o", duty_o, ed);
            check("phase_o", phase_o, ep);
            check("go_beat1", go_out, 1);
            check("data_beat1", dataout, ed);
            check("busy_emit1", busy, 1);
            @(negedge clk);
            check("valid_one_cycle", valid, 0);
            check("go_beat2", go_out, 1);
            check("data_beat2", dataout, ep);
            check("busy_emit2", busy, 1);
            @(negedge clk);
            check("go_end", go_out, 0);
            check("data_end", dataout, 0);
            check("busy_end", busy, 0);
        end
    endtask

    initial begin
        int k;
        int nvalid;
        int vduty;
        int vphase;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_duty", duty_o, 0);
        check("rst_phase", phase_o, 0);
        check("rst_go", go_out, 0);
        check("rst_data", dataout, 0);
        rst = 1'b0;

        measure(1, 3);
        measure(5, 1);
        measure(7, 0);
        measure(5, 6);
        measure(0, 4);
        measure(8, 2);

        // clk0 stuck low: err after the ARM timeout
        hold0 = 1'b1;
        gen_duty  = 3;
        gen_phase = 1;
        repeat (10) @(negedge clk);
        pulse_start();
        check("arm_busy", busy, 1);
        k = 0;
        while (!err && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("arm_timeout_cycles", k, 16);
        check("arm_err_busy", busy, 0);
        check("arm_err_duty_kept", duty_o, exp_duty);
        hold0 = 1'b0;

        // start held high for the whole measurement: exactly one result
        gen_duty  = 6;
        gen_phase = 2;
        repeat (10) @(negedge clk);
        start  = 1'b1;
        nvalid = 0;
        vduty  = -1;
        vphase = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (valid) begin
                nvalid++;
                vduty  = int'(duty_o);
                vphase = int'(phase_o);
            end
            start = busy;
        end
        start = 1'b0;
        check("busy_start_nvalid", nvalid, 1);
        check("busy_start_duty", vduty, 6);
        check("busy_start_phase", vphase, 2);
        exp_duty  = 6;
        exp_phase = 2;

        // reset in the middle of DUTY
        gen_duty  = 7;
        gen_phase = 0;
        repeat (10) @(negedge clk);
        pulse_start();
        k = 0;
        while (ph != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        while (ph != 3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_duty", duty_o, 0);
        check("mid_rst_phase", phase_o, 0);
        check("mid_rst_go", go_out, 0);
        check("mid_rst_data", dataout, 0);
        exp_duty  = 0;
        exp_phase = 0;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid || err) nvalid++;
        end
        check("mid_rst_no_result", nvalid, 0);
        measure(3, 5);

        for (int i = 0; i < 16; i++) begin
            measure(int'($urandom_range(0, 8)), int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
